// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - execute stage with single-cycle ALU and iterative multiply/divide unit
module ex_stage_mdu #(
    parameter int WIDTH      = 32,
    parameter int MDU_CYCLES = 32
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             Flush_In,
    input  logic             RegWriteEN_In,
    input  logic             Mem2RegSEL_In,
    input  logic             MemWriteEN_In,
    input  logic             Branch_In,
    input  logic [3:0]       ALUCtrl_In,
    input  logic             ALUSrc_In,
    input  logic             RegDstSEL_In,
    input  logic [WIDTH-1:0] RegData1_In,
    input  logic [WIDTH-1:0] RegData2_In,
    input  logic [WIDTH-1:0] ImmSignExt_In,
    input  logic [4:0]       RTAddr_In,
    input  logic [4:0]       RDAddr_In,
    output logic             Stall_Out,
    output logic             RegWriteEN_Out,
    output logic             Mem2RegSEL_Out,
    output logic             MemWriteEN_Out,
    output logic             BranchTaken_Out,
    output logic [WIDTH-1:0] ALUResult_Out,
    output logic [WIDTH-1:0] StoreData_Out,
    output logic [4:0]       WriteAddr_Out
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(MDU_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  rem_q;    // divide remainder, or multiply accumulator
    logic [WIDTH-1:0]  quo_q;    // dividend shifting into quotient, or multiplier
    logic [WIDTH-1:0]  dsr_q;    // divisor, or left-shifting multiplicand
    logic [3:0]        op_q;
    logic              hold_regwrite;
    logic              hold_mem2reg;
    logic              hold_memwrite;
    logic              hold_taken;
    logic [WIDTH-1:0]  hold_store;
    logic [4:0]        hold_waddr;

    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  alu_res;
    logic [SW-1:0]     shamt;
    logic              is_mdu;
    logic              taken;
    logic [4:0]        waddr;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH-1:0]  rem_sub;
    logic              rem_ge;
    logic [WIDTH-1:0]  mdu_res;

    // Operand selection and single-cycle ALU
    always_comb begin
        op_b   = ALUSrc_In ? ImmSignExt_In : RegData2_In;
        shamt  = op_b[SW-1:0];
        is_mdu = (ALUCtrl_In >= 4'd10) && (ALUCtrl_In <= 4'd12);
        taken  = Branch_In && (RegData1_In == RegData2_In);
        waddr  = RegDstSEL_In ? RDAddr_In : RTAddr_In;
        case (ALUCtrl_In)
            4'd0:    alu_res = RegData1_In + op_b;
            4'd1:    alu_res = RegData1_In - op_b;
            4'd2:    alu_res = RegData1_In & op_b;
            4'd3:    alu_res = RegData1_In | op_b;
            4'd4:    alu_res = RegData1_In ^ op_b;
            4'd5:    alu_res = ~(RegData1_In | op_b);
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(RegData1_In) < $signed(op_b))};
            4'd7:    alu_res = RegData1_In << shamt;
            4'd8:    alu_res = RegData1_In >> shamt;
            4'd9:    alu_res = $signed(RegData1_In) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One restoring-division step; a zero divisor naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, dsr_q};
        rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;
        mdu_res   = (op_q == 4'd11) ? quo_q : rem_q;
    end

    // The stall covers the presentation cycle in IDLE plus every BUSY cycle
    assign Stall_Out = RESET_N && ((state == BUSY) ||
                                   ((state == IDLE) && is_mdu && !Flush_In));

    // Control FSM, MDU iteration and EX/MEM register; outputs default to a bubble each edge
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state           <= IDLE;
            count           <= '0;
            rem_q           <= '0;
            quo_q           <= '0;
            dsr_q           <= '0;
            op_q            <= '0;
            hold_regwrite   <= 1'b0;
            hold_mem2reg    <= 1'b0;
            hold_memwrite   <= 1'b0;
            hold_taken      <= 1'b0;
            hold_store      <= '0;
            hold_waddr      <= '0;
            RegWriteEN_Out  <= 1'b0;
            Mem2RegSEL_Out  <= 1'b0;
            MemWriteEN_Out  <= 1'b0;
            BranchTaken_Out <= 1'b0;
            ALUResult_Out   <= '0;
            StoreData_Out   <= '0;
            WriteAddr_Out   <= '0;
        end else begin
            RegWriteEN_Out  <= 1'b0;
            Mem2RegSEL_Out  <= 1'b0;
            MemWriteEN_Out  <= 1'b0;
            BranchTaken_Out <= 1'b0;
            ALUResult_Out   <= '0;
            StoreData_Out   <= '0;
            WriteAddr_Out   <= '0;
            if (Flush_In) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_mdu) begin
                            state         <= BUSY;
                            count         <= '0;
                            rem_q         <= '0;
                            quo_q         <= RegData1_In;
                            dsr_q         <= op_b;
                            op_q          <= ALUCtrl_In;
                            hold_regwrite <= RegWriteEN_In;
                            hold_mem2reg  <= Mem2RegSEL_In;
                            hold_memwrite <= MemWriteEN_In;
                            hold_taken    <= taken;
                            hold_store    <= RegData2_In;
                            hold_waddr    <= waddr;
                        end else begin
                            RegWriteEN_Out  <= RegWriteEN_In;
                            Mem2RegSEL_Out  <= Mem2RegSEL_In;
                            MemWriteEN_Out  <= MemWriteEN_In;
                            BranchTaken_Out <= taken;
                            ALUResult_Out   <= alu_res;
                            StoreData_Out   <= RegData2_In;
                            WriteAddr_Out   <= waddr;
                        end
                    end
                    BUSY: begin
                        if (op_q == 4'd10) begin
                            rem_q <= rem_q + (quo_q[0] ? dsr_q : '0);
                            quo_q <= quo_q >> 1;
                            dsr_q <= dsr_q << 1;
                        end else begin
                            rem_q <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], rem_ge};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(MDU_CYCLES - 1)) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state           <= IDLE;
                        RegWriteEN_Out  <= hold_regwrite;
                        Mem2RegSEL_Out  <= hold_mem2reg;
                        MemWriteEN_Out  <= hold_memwrite;
                        BranchTaken_Out <= hold_taken;
                        ALUResult_Out   <= mdu_res;
                        StoreData_Out   <= hold_store;
                        WriteAddr_Out   <= hold_waddr;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
